// File: rtl/cla_adder_display.sv
// Sequential carry-look-ahead adder, one 4-bit group per clock,
// with a time-multiplexed seven-segment display of sum and carry.
module cla_adder_display #(
    parameter int WIDTH       = 16,
    parameter int REFRESH_CNT = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             valid,
    output logic [6:0]       seg,
    output logic [7:0]       an
);

    localparam int NG  = WIDTH / 4;
    localparam int RCW = (REFRESH_CNT > 1) ? $clog2(REFRESH_CNT) : 1;
    localparam logic [2:0]     LAST_G  = 3'(NG - 1);
    localparam logic [2:0]     CARRY_D = 3'(NG);
    localparam logic [RCW-1:0] RC_MAX  = RCW'(REFRESH_CNT - 1);

    typedef enum logic {IDLE, ADD} state_t;

    state_t           r_state;
    state_t           w_next;
    logic             w_accept;
    logic             w_last;

    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic             r_valid;
    logic [2:0]       r_g;

    logic [3:0]       w_a4;
    logic [3:0]       w_b4;
    logic [3:0]       w_p;
    logic [3:0]       w_gen;
    logic             w_c1;
    logic             w_c2;
    logic             w_c3;
    logic             w_c4;
    logic [3:0]       w_s;
    logic [WIDTH-1:0] w_acc_next;

    logic [RCW-1:0]   r_rc;
    logic [2:0]       r_d;
    logic [6:0]       r_seg;
    logic [7:0]       r_an;
    logic [3:0]       w_nib;
    logic             w_blank;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0:    glyph = 7'b0000001;
            4'h1:    glyph = 7'b1001111;
            4'h2:    glyph = 7'b0010010;
            4'h3:    glyph = 7'b0000110;
            4'h4:    glyph = 7'b1001100;
            4'h5:    glyph = 7'b0100100;
            4'h6:    glyph = 7'b0100000;
            4'h7:    glyph = 7'b0001111;
            4'h8:    glyph = 7'b0000000;
            4'h9:    glyph = 7'b0000100;
            4'hA:    glyph = 7'b0001000;
            4'hB:    glyph = 7'b1100000;
            4'hC:    glyph = 7'b0110001;
            4'hD:    glyph = 7'b1000010;
            4'hE:    glyph = 7'b0110000;
            default: glyph = 7'b0111000;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_last   = 1'b0;
        unique case (r_state)
            IDLE: if (start) begin
                w_accept = 1'b1;
                w_next   = ADD;
            end
            ADD: if (r_g == LAST_G) begin
                w_last = 1'b1;
                w_next = IDLE;
            end
        endcase
    end

    always_comb begin
        w_a4       = '0;
        w_b4       = '0;
        w_acc_next = r_acc;
        for (int k = 0; k < NG; k++) begin
            if (3'(k) == r_g) begin
                w_a4 = r_opa[4*k +: 4];
                w_b4 = r_opb[4*k +: 4];
            end
        end
        w_p   = w_a4 ^ w_b4;
        w_gen = w_a4 & w_b4;
        w_c1  = w_gen[0] | (w_p[0] & r_carry);
        w_c2  = w_gen[1] | (w_p[1] & w_gen[0])
              | (w_p[1] & w_p[0] & r_carry);
        w_c3  = w_gen[2] | (w_p[2] & w_gen[1])
              | (w_p[2] & w_p[1] & w_gen[0])
              | (w_p[2] & w_p[1] & w_p[0] & r_carry);
        w_c4  = w_gen[3] | (w_p[3] & w_gen[2])
              | (w_p[3] & w_p[2] & w_gen[1])
              | (w_p[3] & w_p[2] & w_p[1] & w_gen[0])
              | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & r_carry);
        w_s   = w_p ^ {w_c3, w_c2, w_c1, r_carry};
        for (int k = 0; k < NG; k++) begin
            if (3'(k) == r_g) w_acc_next[4*k +: 4] = w_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_opa   <= '0;
            r_opb   <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_g     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_accept) begin
                r_opa   <= a;
                r_opb   <= b;
                r_carry <= cin;
                r_acc   <= '0;
                r_g     <= '0;
            end else if (r_state == ADD) begin
                r_acc   <= w_acc_next;
                r_carry <= w_c4;
                r_g     <= r_g + 3'd1;
                if (w_last) begin
                    r_sum   <= w_acc_next;
                    r_cout  <= w_c4;
                    r_valid <= 1'b1;
                end
            end
        end
    end

    // Digit slot NG carries cout; slots above it stay dark.
    always_comb begin
        w_nib   = '0;
        w_blank = (r_d > CARRY_D);
        if (r_d == CARRY_D) w_nib = {3'b000, r_cout};
        for (int k = 0; k < NG; k++) begin
            if (3'(k) == r_d) w_nib = r_sum[4*k +: 4];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rc  <= '0;
            r_d   <= '0;
            r_an  <= 8'b11111110;
            r_seg <= 7'b0000001;
        end else begin
            if (r_rc == RC_MAX) begin
                r_rc <= '0;
                r_d  <= r_d + 3'd1;
            end else begin
                r_rc <= r_rc + 1'b1;
            end
            r_an  <= w_blank ? 8'hFF : ~(8'b1 << r_d);
            r_seg <= w_blank ? 7'b1111111 : glyph(w_nib);
        end
    end

    assign sum   = r_sum;
    assign cout  = r_cout;
    assign valid = r_valid;
    assign busy  = (r_state == ADD);
    assign seg   = r_seg;
    assign an    = r_an;

endmodule

// File: tb/tb_cla_adder_display.sv
// Scoreboard bench for cla_adder_display (WIDTH=16, REFRESH_CNT=4).
module tb_cla_adder_display;

    localparam int W  = 16;
    localparam int RC = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
    logic         valid;
    logic [6:0]   seg;
    logic [7:0]   an;

    cla_adder_display #(.WIDTH(W), .REFRESH_CNT(RC)) dut (
        .clk(clk), .rst(rst), .start(start),
        .a(a), .b(b), .cin(cin),
        .sum(sum), .cout(cout), .busy(busy), .valid(valid),
        .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        int           at;
        string        name;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every valid pulse must match the oldest outstanding add.
    exp_t e;
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_valid: got valid=1 sum=%h expected no pulse", sum);
            end else begin
                e = q.pop_front();
                chk({e.name, "_sum"}, 32'(sum), 32'(e.s));
                chk({e.name, "_cout"}, 32'(cout), 32'(e.c));
                chk({e.name, "_latency"}, cyc, e.at);
            end
        end
    end

    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic ic, input logic [W-1:0] es,
                         input logic ec, input string nm);
        @(negedge clk);
        a = ia; b = ib; cin = ic; start = 1'b1;
        q.push_back('{es, ec, cyc + 5, nm});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid(input string nm);
        for (int i = 0; i < 20 && valid !== 1'b1; i++) @(negedge clk);
        if (valid !== 1'b1) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: got no valid expected valid within 20 cycles", nm);
        end
    endtask

    logic [7:0] exp_an [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7,
                               8'hEF, 8'hFF, 8'hFF, 8'hFF};
    logic [6:0] exp_seg[8] = '{7'b1000010, 7'b0110001, 7'b1100000,
                               7'b0001000, 7'b1001111, 7'b1111111,
                               7'b1111111, 7'b1111111};

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] prev;
        bit         found;

        // Reset
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_sum", 32'(sum), 32'h0);
        chk("rst_cout", 32'(cout), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_an", 32'(an), 32'hFE);
        chk("rst_seg", 32'(seg), 32'(7'b0000001));
        rst = 1'b0;

        // Basic add, busy for exactly four cycles
        issue(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, "basic");
        for (int i = 0; i < 4; i++) begin
            chk("basic_busy_hi", 32'(busy), 32'h1);
            @(negedge clk);
        end
        chk("basic_busy_lo", 32'(busy), 32'h0);
        chk("basic_valid_hi", 32'(valid), 32'h1);
        @(negedge clk);
        chk("basic_valid_pulse", 32'(valid), 32'h0);

        // Full carry ripple
        issue(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, "ripple");
        wait_valid("ripple");
        @(negedge clk);

        // Overflow, ignored start while busy, then back-to-back
        issue(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, "ovf");
        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_valid("ovf");
        a = 16'h0001; b = 16'h0001; cin = 1'b0; start = 1'b1;
        q.push_back('{16'h0002, 1'b0, cyc + 5, "b2b"});
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 16'h0007; b = 16'h0007; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_valid("b2b");
        @(negedge clk);

        // Reset in the middle of an add
        a = 16'h1111; b = 16'h2222; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_sum", 32'(sum), 32'h0);
        chk("midrst_cout", 32'(cout), 32'h0);
        chk("midrst_valid", 32'(valid), 32'h0);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("midrst_idle", 32'(busy), 32'h0);
        chk("midrst_sum_hold", 32'(sum), 32'h0);

        // Display scan of 1ABCD
        issue(16'hFFFF, 16'hABCE, 1'b0, 16'hABCD, 1'b1, "disp");
        wait_valid("disp");
        prev  = an;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (an == 8'hFE && prev != 8'hFE) found = 1'b1;
            else prev = an;
        end
        chk("scan_sync", 32'(found), 32'h1);
        for (int r = 0; r < 2; r++) begin
            for (int s = 0; s < 8; s++) begin
                for (int k = 0; k < RC; k++) begin
                    chk($sformatf("scan_an_s%0d", s), 32'(an), 32'(exp_an[s]));
                    chk($sformatf("scan_seg_s%0d", s), 32'(seg), 32'(exp_seg[s]));
                    @(negedge clk);
                end
            end
        end
        chk("scan_wrap_an", 32'(an), 32'hFE);

        repeat (4) @(negedge clk);
        chk("queue_drain", q.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
